regfile_mp_sb: RTL

//  Parametrised multi-port integer register file with write-to-read bypass and a per-register busy scoreboard.

---
 rtl/regfile_mp_sb_pkg.sv | 14 +
 rtl/regfile_mp_sb_if.sv | 32 +++
 rtl/regfile_mp_sb_scoreboard.sv | 53 +++++
 rtl/regfile_mp_sb.sv | 68 ++++++
 4 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults, address-width helper and word/address types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NREG_DEF = 32;

  function automatic int unsigned addr_width(input int unsigned nreg);
    return $clog2(nreg);
  endfunction

  typedef logic [addr_width(NREG_DEF)-1:0] reg_addr_t;
  typedef logic [XLEN_DEF-1:0]             xword_t;

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read/write/issue bundle between the pipeline (master) and the register file (slave).
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1
);
  localparam int unsigned AW = addr_width(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      w_en;
  logic [NWR*AW-1:0]   w_addr;
  logic [NWR*XLEN-1:0] w_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_addr, w_en, w_addr, w_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, w_en, w_addr, w_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins a same-cycle tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1,
  localparam int unsigned AW      = addr_width(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  input  logic [NWR-1:0]    w_en,
  input  logic [NWR*AW-1:0] w_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NRD-1:0]    rd_busy,
  output logic [NREG-1:0]   busy_vec
);

  // Bit 0 is forced low when register 0 is hardwired.
  localparam logic [NREG-1:0] KEEP = {{(NREG-1){1'b1}}, ~ZERO_REG};

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_now;
  logic [NREG-1:0] clear_now;

  always_comb begin
    set_now   = '0;
    clear_now = '0;
    if (iss_en) set_now[iss_addr] = 1'b1;
    for (int unsigned w = 0; w < NWR; w++)
      if (w_en[w]) clear_now[w_addr[w*AW +: AW]] = 1'b1;
    busy_d = ((busy_q & ~clear_now) | set_now) & KEEP;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra         = rd_addr[p*AW +: AW];
    assign rd_busy[p] = busy_q[ra] & ~(BYPASS & clear_now[ra]);
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised NRD-read / NWR-write register file with write-to-read bypass and busy scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 1,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input logic              clk,
  input logic              rst,
  regfile_mp_sb_if.slave   bus
);

  localparam int unsigned AW = addr_width(NREG);

  logic [XLEN-1:0] regs [NREG];

  // Later loop iterations override earlier ones, so the highest write port wins a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int unsigned w = 0; w < NWR; w++)
        if (bus.w_en[w] && !(ZERO_REG && bus.w_addr[w*AW +: AW] == '0))
          regs[bus.w_addr[w*AW +: AW]] <= bus.w_data[w*XLEN +: XLEN];
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdata;

    assign ra = bus.rd_addr[p*AW +: AW];

    always_comb begin
      rdata = regs[ra];
      if (BYPASS)
        for (int unsigned w = 0; w < NWR; w++)
          if (bus.w_en[w] && bus.w_addr[w*AW +: AW] == ra)
            rdata = bus.w_data[w*XLEN +: XLEN];
      if (ZERO_REG && ra == '0) rdata = '0;
    end

    assign bus.rd_data[p*XLEN +: XLEN] = rdata;
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (bus.rd_addr),
    .w_en     (bus.w_en),
    .w_addr   (bus.w_addr),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .rd_busy  (bus.rd_busy),
    .busy_vec (bus.busy_vec)
  );

endmodule
